// File: rtl/histo_equalizer_if.sv
// Pixel stream and cumulative-bin handshake bundle for the histogram equalizer.
// slave = equalizer side, master = driver of pixels and bins.
interface histo_equalizer_if #(
  parameter int CUM_WIDTH = 20
);
  logic                 iFval;
  logic                 iDval;
  logic [7:0]           iGrey;
  logic                 iCum_Valid;
  logic [7:0]           iCum_Bin;
  logic [CUM_WIDTH-1:0] iCum_Data;
  logic                 oCum_Ready;
  logic [7:0]           oGrey_Eq;
  logic                 oDval;
  logic                 oLut_Active;

  modport slave (
    input  iFval, iDval, iGrey, iCum_Valid, iCum_Bin, iCum_Data,
    output oCum_Ready, oGrey_Eq, oDval, oLut_Active
  );

  modport master (
    output iFval, iDval, iGrey, iCum_Valid, iCum_Bin, iCum_Data,
    input  oCum_Ready, oGrey_Eq, oDval, oLut_Active
  );
endinterface

// File: rtl/histo_equalizer.sv
// Builds a 256-entry equalization LUT from cumulative bin counts with a serial divider,
// double-buffers it, and remaps the pixel stream through the active bank in 2 cycles.
module histo_equalizer #(
  parameter int NUM_PIXELS = 1024,
  parameter int CUM_WIDTH  = 20
) (
  input logic             iPclk,
  input logic             iRST,
  histo_equalizer_if.slave bus
);
  localparam int NW  = CUM_WIDTH + 8;
  localparam int NW1 = NW + 1;
  localparam int CW  = $clog2(NW);
  localparam logic [NW:0]   DIVISOR = NW1'(NUM_PIXELS);
  localparam logic [CW-1:0] LAST    = CW'(NW - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_WRITE} state_e;

  state_e        state_q, state_d;
  logic [NW-1:0] num_q, num_d;
  logic [NW-1:0] rem_q, rem_d;
  logic [NW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    bin_q, bin_d;
  logic          complete_q, complete_d;
  logic          act_sel_q, act_sel_d;
  logic          lut_active_q, lut_active_d;
  logic          fval_q;

  logic          accept, fval_rise, swap, lut_we;
  logic [NW:0]   rem_shift;
  logic [7:0]    lut_wdat;

  logic [7:0]    lut_q [0:511];
  logic [7:0]    lut_rd_q;
  logic          dval1_q, dval2_q;
  logic [7:0]    grey1_q, grey2_q;

  assign bus.oCum_Ready = (state_q == S_IDLE) && !iRST;
  assign accept         = bus.iCum_Valid && bus.oCum_Ready;
  assign fval_rise      = bus.iFval && !fval_q;
  // Swap looks at the pre-accept complete flag, so a same-cycle accept cannot block it.
  assign swap           = fval_rise && complete_q && (state_q == S_IDLE);
  assign rem_shift      = {rem_q, num_q[NW-1]};
  assign lut_wdat       = (|quo_q[NW-1:8]) ? 8'hFF : quo_q[7:0];

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    bin_d        = bin_q;
    complete_d   = complete_q;
    act_sel_d    = act_sel_q;
    lut_active_d = lut_active_q;
    lut_we       = 1'b0;

    if (swap) begin
      act_sel_d    = !act_sel_q;
      lut_active_d = 1'b1;
      complete_d   = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          num_d   = NW'(bus.iCum_Data) * NW'(255);
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          bin_d   = bus.iCum_Bin;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        num_d = num_q << 1;
        if (rem_shift >= DIVISOR) begin
          rem_d = NW'(rem_shift - DIVISOR);
          quo_d = {quo_q[NW-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[NW-1:0];
          quo_d = {quo_q[NW-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_WRITE;
      end
      S_WRITE: begin
        lut_we = 1'b1;
        if (bin_q == 8'hFF) complete_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iPclk) begin
    if (iRST) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      bin_q        <= '0;
      complete_q   <= 1'b0;
      act_sel_q    <= 1'b0;
      lut_active_q <= 1'b0;
      fval_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      bin_q        <= bin_d;
      complete_q   <= complete_d;
      act_sel_q    <= act_sel_d;
      lut_active_q <= lut_active_d;
      fval_q       <= bus.iFval;
    end
  end

  // LUT storage has no reset; passthrough hides stale contents until the first swap.
  always_ff @(posedge iPclk) begin
    if (lut_we) lut_q[{~act_sel_q, bin_q}] <= lut_wdat;
    lut_rd_q <= lut_q[{act_sel_q, bus.iGrey}];
  end

  always_ff @(posedge iPclk) begin
    if (iRST) begin
      dval1_q <= 1'b0;
      grey1_q <= '0;
      dval2_q <= 1'b0;
      grey2_q <= '0;
    end else begin
      dval1_q <= bus.iDval;
      grey1_q <= bus.iGrey;
      dval2_q <= dval1_q;
      grey2_q <= lut_active_q ? lut_rd_q : grey1_q;
    end
  end

  assign bus.oGrey_Eq    = grey2_q;
  assign bus.oDval       = dval2_q;
  assign bus.oLut_Active = lut_active_q;
endmodule

// File: doc/histo_equalizer.md
HISTO_EQUALIZER -- requirements
Module: histo_equalizer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 1024, pixels per frame (32x32 image).
REQ-002 SHALL have parameter CUM_WIDTH, default 20, width of cumulative-count input.
REQ-003 SHALL have port iPclk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port iRST, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port iFval, input, 1, frame valid.
REQ-006 SHALL have port iDval, input, 1, pixel data valid.
REQ-007 SHALL have port iGrey, input, 8, greyscale pixel.
REQ-008 SHALL have port iCum_Valid, input, 1, cumulative-bin offer from the histogram stage.
REQ-009 SHALL have port iCum_Bin, input, 8, bin index of offered entry.
REQ-010 SHALL have port iCum_Data, input, CUM_WIDTH, cumulative count for that bin.
REQ-011 SHALL have port oCum_Ready, output, 1, block can accept a bin this cycle.
REQ-012 SHALL have port oGrey_Eq, output, 8, equalized pixel.
REQ-013 SHALL have port oDval, output, 1, oGrey_Eq valid.
REQ-014 SHALL have port oLut_Active, output, 1, equalization LUT in use (0 = passthrough).

Function
REQ-015 A bin SHALL be accepted only on a cycle with iCum_Valid=1 and oCum_Ready=1.
REQ-016 Per accepted bin, the block SHALL compute LUT value = floor(iCum_Data*255/NUM_PIXELS), saturated to 255.
REQ-017 The division SHALL be a sequential restoring divider, one quotient bit per cycle, numerator width CUM_WIDTH+8.
REQ-018 The FSM SHALL have states IDLE (oCum_Ready=1), DIV (CUM_WIDTH+8 cycles), WRITE (1 cycle, stores the result at index iCum_Bin in the shadow bank), then return to IDLE.
REQ-019 oCum_Ready SHALL be 0 in DIV and WRITE; offers during these states are not consumed.
REQ-020 The LUT SHALL be double-buffered: 256x8 active bank, 256x8 shadow bank.
REQ-021 The shadow bank SHALL be marked complete when bin 255 is written; bins may arrive in any order, and the last write to an index wins.
REQ-022 On an iFval rising edge with the shadow bank complete and FSM in IDLE, the banks SHALL swap, oLut_Active SHALL go to 1, and the complete flag SHALL clear.
REQ-023 On an iFval rising edge with the shadow bank incomplete or FSM not in IDLE, there SHALL be no swap; the active LUT stays unchanged and the swap is retried at the next iFval rising edge.
REQ-024 A bank swap SHALL occur only on an iFval rising edge, never mid-frame.
REQ-025 Pixel path latency SHALL be exactly 2 cycles: oDval(t+2)=iDval(t).
REQ-026 oGrey_Eq(t+2) SHALL be active_LUT[iGrey(t)] when oLut_Active=1, else iGrey(t).
REQ-027 The pixel path SHALL run concurrently with LUT construction with no stall.
REQ-028 An accept and an iFval rising edge in the same cycle SHALL both take effect: the accept enters DIV and the swap check evaluates the pre-accept complete flag.

Reset
REQ-029 While iRST=1 at a clock edge: FSM=IDLE, oCum_Ready=0 during reset then 1 on the first cycle after, oDval=0, oGrey_Eq=0, oLut_Active=0, complete flag=0, divider registers cleared.
REQ-030 Reset during DIV SHALL abandon the bin with no LUT write; LUT RAM contents need not clear, because oLut_Active=0 forces passthrough.
REQ-031 Pipeline registers SHALL not carry data across reset; the first valid output appears 2 cycles after the first iDval=1 following reset release.

Verification
REQ-032 Passthrough: after reset, iDval=1, iGrey=0x5A -> oDval=1, oGrey_Eq=0x5A two cycles later, oLut_Active=0.
REQ-033 Arithmetic: NUM_PIXELS=1024; bin 10 cum=512 -> LUT[10]=127; bin 20 cum=1024 -> 255; bin 0 cum=0 -> 0; bin 30 cum=2000 -> 255 (saturated).
REQ-034 Handshake: hold iCum_Valid=1 continuously -> one accept per 30 cycles (1 IDLE + 28 DIV + 1 WRITE); oCum_Ready low for exactly 29 cycles after each accept.
REQ-035 Swap: load all 256 bins with cum=4*(b+1), then iFval rising edge -> oLut_Active=1; iGrey=0x7F -> oGrey_Eq=0x7F (512*255/1024=127) two cycles later.
REQ-036 No swap: iFval rising edge after bin 255 accepted but still in DIV -> oLut_Active unchanged; swap occurs at the next iFval rising edge.
REQ-037 Reset mid-DIV: assert iRST 10 cycles after an accept -> no LUT write, oLut_Active=0, oCum_Ready=1 on the cycle after reset release.
